// File: rtl/maxpool_layer.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_layer
// Purpose  : 2x2, stride-2 signed max-pool over a pair of completed line BRAMs.
//            A start pulse launches one pass. The pass reads both lines of the
//            selected pair column by column. It emits one pooled value per
//            pair of columns through a simple write port.
// Ports    : clk, reset (sync, active-high)
//            start, bank_sel        - pass request / line-pair select (0: d0/d1,
//                                     1: d2/d3), bank latched at start
//            d0..d3                 - BRAM read data, channels a|b|c MSB-first
//            rden, rdaddr           - shared BRAM read port (1-cycle latency)
//            wren, wraddr, q        - pooled output write port
//            busy, done, overrun    - pass status, done / rejected-start pulses
// Revision : 1.0 - initial release
// ============================================================================
module maxpool_layer #(
  parameter int BD       = 18,
  parameter int INWIDTH  = 1918,
  parameter int OUTWIDTH = 959,
  parameter int AW       = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            bank_sel,
  input  logic [3*BD-1:0] d0,
  input  logic [3*BD-1:0] d1,
  input  logic [3*BD-1:0] d2,
  input  logic [3*BD-1:0] d3,
  output logic            rden,
  output logic [AW-1:0]   rdaddr,
  output logic            wren,
  output logic [AW-1:0]   wraddr,
  output logic [3*BD-1:0] q,
  output logic            busy,
  output logic            done,
  output logic            overrun
);

  localparam logic [AW-1:0] LAST_COL = AW'(INWIDTH - 1);
  localparam logic [AW-1:0] OUT_LIM  = AW'(OUTWIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic            bank;     // line pair captured at start
  logic            dvalid;   // BRAM data on d* is valid this cycle
  logic [AW-1:0]   dcol;     // column index of the data on d*
  logic [3*BD-1:0] hold;     // per-channel max of the even column

  logic [3*BD-1:0] top;
  logic [3*BD-1:0] bot;
  logic [3*BD-1:0] colmax;
  logic [3*BD-1:0] winmax;
  logic [AW-1:0]   pair_idx;

  assign top      = bank ? d2 : d0;
  assign bot      = bank ? d3 : d1;
  assign pair_idx = {1'b0, dcol[AW-1:1]};

  // Vertical max of the current column, then horizontal max with the held
  // even column. All comparisons are signed and per channel.
  generate
    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
      logic signed [BD-1:0] t_v;
      logic signed [BD-1:0] b_v;
      logic signed [BD-1:0] c_v;
      logic signed [BD-1:0] h_v;
      assign t_v = top[ch*BD +: BD];
      assign b_v = bot[ch*BD +: BD];
      assign c_v = (t_v > b_v) ? t_v : b_v;
      assign h_v = hold[ch*BD +: BD];
      assign colmax[ch*BD +: BD] = c_v;
      assign winmax[ch*BD +: BD] = (h_v > c_v) ? h_v : c_v;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bank    <= 1'b0;
      dvalid  <= 1'b0;
      dcol    <= '0;
      hold    <= '0;
      rden    <= 1'b0;
      rdaddr  <= '0;
      wren    <= 1'b0;
      wraddr  <= '0;
      q       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      wren    <= 1'b0;

      // Read data arrives one cycle after the address; track its column.
      dvalid <= rden;
      dcol   <= rdaddr;

      if (dvalid) begin
        if (!dcol[0]) begin
          // Even column (including a trailing odd-width column, which is
          // simply never paired and so never written).
          hold <= colmax;
        end else if (pair_idx < OUT_LIM) begin
          q      <= winmax;
          wren   <= 1'b1;
          wraddr <= pair_idx;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state  <= READ;
            bank   <= bank_sel;
            busy   <= 1'b1;
            rden   <= 1'b1;
            rdaddr <= '0;
          end
        end
        READ: begin
          if (start) overrun <= 1'b1;
          if (rdaddr == LAST_COL) begin
            rden   <= 1'b0;
            rdaddr <= '0;
            state  <= DRAIN;
          end else begin
            rdaddr <= rdaddr + 1'b1;
          end
        end
        DRAIN: begin
          if (start) overrun <= 1'b1;
          // Once the read pipeline is empty the last window has been written.
          if (!dvalid) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maxpool_layer.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxpool_layer
// Purpose  : Self-checking bench for maxpool_layer. A narrow instance
//            (INWIDTH=8) covers the detailed cases. A default-width instance
//            covers one full-size pass. BRAMs are modelled with a 1-cycle read
//            latency, and expected pooled lines come from a plain array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maxpool_layer;

  localparam int BD = 18;
  localparam int DW = 3 * BD;
  localparam int AW = 11;
  localparam int SW = 8;
  localparam int BW = 1918;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_s, start_b, bank_sel;
  logic [DW-1:0] s_d0, s_d1, s_d2, s_d3, b_d0, b_d1, b_d2, b_d3;
  logic s_rden, s_wren, s_busy, s_done, s_ovr;
  logic b_rden, b_wren, b_busy, b_done, b_ovr;
  logic [AW-1:0] s_rdaddr, s_wraddr, b_rdaddr, b_wraddr;
  logic [DW-1:0] s_q, b_q;

  maxpool_layer #(.BD(BD), .INWIDTH(SW), .OUTWIDTH(SW/2), .AW(AW)) u_small (
    .clk(clk), .reset(reset), .start(start_s), .bank_sel(bank_sel),
    .d0(s_d0), .d1(s_d1), .d2(s_d2), .d3(s_d3),
    .rden(s_rden), .rdaddr(s_rdaddr), .wren(s_wren), .wraddr(s_wraddr),
    .q(s_q), .busy(s_busy), .done(s_done), .overrun(s_ovr));

  maxpool_layer u_big (
    .clk(clk), .reset(reset), .start(start_b), .bank_sel(bank_sel),
    .d0(b_d0), .d1(b_d1), .d2(b_d2), .d3(b_d3),
    .rden(b_rden), .rdaddr(b_rdaddr), .wren(b_wren), .wraddr(b_wraddr),
    .q(b_q), .busy(b_busy), .done(b_done), .overrun(b_ovr));

  // Line memories: [instance][line][column]
  logic [DW-1:0] mem [0:1][0:3][0:2047];

  always @(posedge clk) begin
    if (s_rden) begin
      s_d0 <= mem[0][0][s_rdaddr]; s_d1 <= mem[0][1][s_rdaddr];
      s_d2 <= mem[0][2][s_rdaddr]; s_d3 <= mem[0][3][s_rdaddr];
    end
    if (b_rden) begin
      b_d0 <= mem[1][0][b_rdaddr]; b_d1 <= mem[1][1][b_rdaddr];
      b_d2 <= mem[1][2][b_rdaddr]; b_d3 <= mem[1][3][b_rdaddr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; int cyc; int addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int id; int cyc; } ev_t;
  wr_t wr_q[$];
  ev_t done_q[$];
  ev_t ovr_q[$];
  bit  busy_h [0:1][0:8191];

  always @(negedge clk) begin
    if (cyc < 8192) begin
      busy_h[0][cyc] <= s_busy;
      busy_h[1][cyc] <= b_busy;
    end
    if (s_wren) wr_q.push_back(wr_t'{0, cyc, int'(s_wraddr), s_q});
    if (b_wren) wr_q.push_back(wr_t'{1, cyc, int'(b_wraddr), b_q});
    if (s_done) done_q.push_back(ev_t'{0, cyc});
    if (b_done) done_q.push_back(ev_t'{1, cyc});
    if (s_ovr)  ovr_q.push_back(ev_t'{0, cyc});
    if (b_ovr)  ovr_q.push_back(ev_t'{1, cyc});
  end

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] expv [0:1023];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack3(input int a, input int b, input int c);
    return {BD'(a), BD'(b), BD'(c)};
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge: start is high for exactly the current cycle T.
  task automatic pulse_start(input int id, input bit bs, output int t);
    t = cyc;
    bank_sel = bs;
    if (id == 0) start_s = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic fill_rand(input int id, input int line, input int w, input bit neg);
    logic [31:0]   r;
    logic [BD-1:0] v;
    for (int col = 0; col < w; col++)
      for (int ch = 0; ch < 3; ch++) begin
        r = $urandom;
        v = r[BD-1:0];
        if (neg) begin
          v[BD-1] = 1'b1;
          if (&v) v[0] = 1'b0;   // keep strictly below -1
        end
        mem[id][line][col][ch*BD +: BD] = v;
      end
  endtask

  // Reference: each output is the signed max of its 2x2 window, per channel.
  task automatic model(input int id, input bit bank, input int w);
    int m, v, lb;
    lb = bank ? 2 : 0;
    for (int j = 0; j < w / 2; j++)
      for (int ch = 0; ch < 3; ch++) begin
        m = int'($signed(mem[id][lb][2*j][ch*BD +: BD]));
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++) begin
            v = int'($signed(mem[id][lb+r][2*j+c][ch*BD +: BD]));
            if (v > m) m = v;
          end
        expv[j][ch*BD +: BD] = BD'(m);
      end
  endtask

  task automatic check_pass(input int id, input int t, input int w, input int ovr_at,
                            input string tag);
    int n, ndone, dhit, nbad, nov, ohit;
    n = 0;
    foreach (wr_q[i])
      if (wr_q[i].id == id && wr_q[i].cyc > t && wr_q[i].cyc <= t + 3 + w) begin
        chk($sformatf("%s wr%0d cycle", tag, n), 64'(wr_q[i].cyc - t), 64'(4 + 2 * n));
        chk($sformatf("%s wr%0d addr", tag, n), 64'(wr_q[i].addr), 64'(n));
        if (n < 1024)
          chk($sformatf("%s wr%0d q", tag, n), 64'(wr_q[i].data), 64'(expv[n]));
        n++;
      end
    chk({tag, " write count"}, 64'(n), 64'(w / 2));
    ndone = 0; dhit = 0;
    foreach (done_q[i])
      if (done_q[i].id == id && done_q[i].cyc > t && done_q[i].cyc <= t + 3 + w) begin
        ndone++;
        if (done_q[i].cyc == t + 3 + w) dhit = 1;
      end
    chk({tag, " done at T+3+W"}, 64'(dhit), 64'd1);
    chk({tag, " done count"}, 64'(ndone), 64'd1);
    nbad = 0;
    for (int c = t + 1; c <= t + 2 + w; c++) if (!busy_h[id][c]) nbad++;
    if (busy_h[id][t + 3 + w]) nbad++;
    chk({tag, " busy profile errors"}, 64'(nbad), 64'd0);
    nov = 0; ohit = 0;
    foreach (ovr_q[i])
      if (ovr_q[i].id == id && ovr_q[i].cyc > t && ovr_q[i].cyc <= t + 4 + w) begin
        nov++;
        if (ovr_q[i].cyc == ovr_at) ohit = 1;
      end
    if (ovr_at == 0) chk({tag, " overrun count"}, 64'(nov), 64'd0);
    else begin
      chk({tag, " overrun count"}, 64'(nov), 64'd1);
      chk({tag, " overrun at T+6"}, 64'(ohit), 64'd1);
    end
  endtask

  typedef struct { int tl; int tr; int bl; int br; int e; } rec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t tab [0:7];
    int   ramp [0:3];
    int   t, t2, i, i1, i2, nlate;

    tab[0] = '{-5, -1, -7, -3, -1};
    tab[1] = '{-131072, 131071, -131072, -131072, 131071};
    tab[2] = '{-131072, -131072, -131072, -131072, -131072};
    tab[3] = '{7, 7, 7, 7, 7};
    tab[4] = '{100, -200, 300, -400, 300};
    tab[5] = '{-1, 0, -1, -1, 0};
    tab[6] = '{131071, -1, 5, 6, 131071};
    tab[7] = '{-3, -9, -2, -8, -2};
    ramp = '{11, 13, 15, 17};

    reset = 1'b1; start_s = 1'b0; start_b = 1'b0; bank_sel = 1'b0;
    for (int id = 0; id < 2; id++)
      for (int l = 0; l < 4; l++)
        for (int c = 0; c < 2048; c++) mem[id][l][c] = '0;
    repeat (3) @(negedge clk);
    chk("reset ctrl small", 64'({s_rden, s_rdaddr, s_wren, s_wraddr, s_busy, s_done, s_ovr}), 64'd0);
    chk("reset q small", 64'(s_q), 64'd0);
    chk("reset ctrl big", 64'({b_rden, b_rdaddr, b_wren, b_wraddr, b_busy, b_done, b_ovr}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Ramp pattern: top ch a = column, bottom ch a = 10 + column.
    for (int c = 0; c < SW; c++) begin
      mem[0][0][c] = pack3(c, 0, 0);
      mem[0][1][c] = pack3(10 + c, 0, 0);
    end
    for (int j = 0; j < 4; j++) expv[j] = pack3(ramp[j], 0, 0);
    pulse_start(0, 1'b0, t);
    wait_until(t + SW + 6);
    check_pass(0, t, SW, 0, "ramp");

    // Table-driven windows; each channel gets a different record.
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < 4; j++) begin
        i = 4 * p + j; i1 = (i + 1) % 8; i2 = (i + 2) % 8;
        mem[0][0][2*j]   = pack3(tab[i].tl, tab[i1].tl, tab[i2].tl);
        mem[0][0][2*j+1] = pack3(tab[i].tr, tab[i1].tr, tab[i2].tr);
        mem[0][1][2*j]   = pack3(tab[i].bl, tab[i1].bl, tab[i2].bl);
        mem[0][1][2*j+1] = pack3(tab[i].br, tab[i1].br, tab[i2].br);
        expv[j] = pack3(tab[i].e, tab[i1].e, tab[i2].e);
      end
      pulse_start(0, 1'b0, t);
      wait_until(t + SW + 6);
      check_pass(0, t, SW, 0, $sformatf("table%0d", p));
    end

    // Random passes on bank 0 with different data parked in lines 2/3.
    for (int k = 0; k < 3; k++) begin
      for (int l = 0; l < 4; l++) fill_rand(0, l, SW, 1'b0);
      model(0, 1'b0, SW);
      pulse_start(0, 1'b0, t);
      wait_until(t + SW + 6);
      check_pass(0, t, SW, 0, $sformatf("rand%0d", k));
    end

    // Bank 1: lines 0/1 all-ones, lines 2/3 strictly below -1; bank_sel toggles.
    for (int c = 0; c < SW; c++) begin
      mem[0][0][c] = {3{18'h3FFFF}};
      mem[0][1][c] = {3{18'h3FFFF}};
    end
    fill_rand(0, 2, SW, 1'b1);
    fill_rand(0, 3, SW, 1'b1);
    model(0, 1'b1, SW);
    pulse_start(0, 1'b1, t);
    while (cyc < t + SW + 6) begin
      bank_sel = ~bank_sel;
      @(negedge clk);
    end
    bank_sel = 1'b0;
    check_pass(0, t, SW, 0, "bank1");

    // Start while busy at T+5: overrun at T+6, pass unchanged.
    for (int l = 0; l < 4; l++) fill_rand(0, l, SW, 1'b0);
    model(0, 1'b0, SW);
    pulse_start(0, 1'b0, t);
    wait_until(t + 5);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    wait_until(t + SW + 6);
    check_pass(0, t, SW, t + 6, "overrun");

    // Start in the done cycle: second pass accepted with no gap.
    for (int l = 0; l < 4; l++) fill_rand(0, l, SW, 1'b0);
    model(0, 1'b0, SW);
    pulse_start(0, 1'b0, t);
    wait_until(t + 3 + SW);
    pulse_start(0, 1'b0, t2);
    wait_until(t2 + SW + 6);
    check_pass(0, t, SW, 0, "b2b first");
    check_pass(0, t2, SW, 0, "b2b second");

    // Reset at T+6 abandons the pass.
    pulse_start(0, 1'b0, t);
    wait_until(t + 6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset ctrl", 64'({s_rden, s_rdaddr, s_wren, s_wraddr, s_busy, s_done, s_ovr}), 64'd0);
    chk("midreset q", 64'(s_q), 64'd0);
    repeat (20) @(negedge clk);
    nlate = 0;
    foreach (wr_q[k])   if (wr_q[k].id == 0 && wr_q[k].cyc >= t + 7) nlate++;
    foreach (done_q[k]) if (done_q[k].id == 0 && done_q[k].cyc >= t + 7) nlate++;
    chk("midreset late events", 64'(nlate), 64'd0);
    for (int l = 0; l < 4; l++) fill_rand(0, l, SW, 1'b0);
    model(0, 1'b0, SW);
    pulse_start(0, 1'b0, t);
    wait_until(t + SW + 6);
    check_pass(0, t, SW, 0, "after reset");

    // Full-width pass at default parameters.
    for (int l = 0; l < 4; l++) fill_rand(1, l, BW, 1'b0);
    model(1, 1'b0, BW);
    pulse_start(1, 1'b0, t);
    wait_until(t + BW + 6);
    check_pass(1, t, BW, 0, "full");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/maxpool_layer.md
Name: maxpool_layer

Overview:
- 2x2, stride-2 max-pool stage that consumes the output lines written by the convolution stage into four rotating line BRAMs.
- A single-cycle start pulse (the convolution stage's max-pool trigger) launches one pass over a completed line pair. The pair is line BRAMs 0/1 or 2/3, chosen by bank_sel.
- Each pass reads both lines column by column, takes the per-channel max over each 2x2 window, and writes one pooled output line through a simple write port.

Parameters:
BD, 18, bit width of one channel value (signed two's complement)
INWIDTH, 1918, columns per input line (conv output width)
OUTWIDTH, 959, pooled columns per line = floor(INWIDTH/2)
AW, 11, read/write address width

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse requesting a pass
bank_sel  in  1  0: rows from d0 (top), d1 (bottom); 1: rows from d2 (top), d3 (bottom)
d0,d1,d2,d3  in  3*BD each  BRAM read data, channels a|b|c packed MSB-first
rden  out  1  read enable, shared by all four BRAMs
rdaddr  out  AW  read address, shared by all four BRAMs
wren  out  1  output write enable
wraddr  out  AW  output write address
q  out  3*BD  pooled data, channels a|b|c packed MSB-first
busy  out  1  pass in progress
done  out  1  one-cycle pulse at pass end
overrun  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset: every output goes to 0, the FSM goes to IDLE and the hold registers clear. Reset has priority over everything, including mid-pass; the pass is abandoned with no further wren.
- FSM states: IDLE, READ, DRAIN.
- IDLE -> READ: start sampled high at edge T.
  - bank_sel is latched at T and held for the whole pass.
  - busy is high from T+1 through T+2+INWIDTH.
- READ:
  - rden=1 and rdaddr=k in cycle T+1+k, for k=0..INWIDTH-1.
  - After k=INWIDTH-1: rden=0, rdaddr returns to 0, and the FSM moves to DRAIN.
- BRAM read latency is fixed at 1 cycle: data for address k is valid in cycle T+2+k.
- Per column, each channel computes v = signed max(top, bottom).
  - Even column 2j: v is stored in the hold register.
  - Odd column 2j+1: q = signed max(hold, v) is registered, with wren=1 and wraddr=j, in cycle T+4+2j.
  - wren is 0 in all other cycles (it toggles during READ).
- Odd INWIDTH: the last column is read but discarded, and no output is written for it.
- DRAIN: waits for the last output (j=OUTWIDTH-1) to be written, then goes to IDLE.
- Pass end, cycle T+3+INWIDTH (even INWIDTH): done=1, busy=0, FSM in IDLE.
  - A start sampled in this same cycle is accepted, so back-to-back passes have a zero-cycle gap.
- wraddr restarts at 0 on every pass. It holds its last value between passes. q holds its value while wren=0.
- start while busy: the start is ignored, overrun=1 in the following cycle, and the pass in progress is unaffected.
- Channels are pooled independently. No saturation or rounding; the output width equals the input width.
- Compare rule: signed comparison. On equal values either operand may be chosen (the result is identical).

Test Plan:
- INWIDTH=8, OUTWIDTH=4, bank_sel=0, start at T.
  - Stimulus: d0 ch a = column index, d1 ch a = 10 + column index; other channels 0.
  - Required: wren at T+4, T+6, T+8, T+10 with wraddr 0..3 and q ch a = 11, 13, 15, 17; done at T+11; busy high T+1..T+10.
- Signed check: top = -5, -1; bottom = -7, -3 (all channels).
  - Required: q = -1 in every channel.
  - Also: a window mixing -131072 and +131071 yields +131071.
- bank_sel=1 with d0/d1 driven to 0x3FFFF patterns and d2/d3 carrying the test data.
  - Required: output matches d2/d3 only.
  - Also: toggling bank_sel mid-pass has no effect.
- start reasserted at T+5: overrun pulse at T+6; output sequence and done timing unchanged.
- start in the done cycle: second pass produces first wren at done+4 with wraddr 0.
- reset asserted at T+6 for 1 cycle.
  - Required: the next cycle shows all outputs 0 with no later wren.
  - A new start afterwards gives a correct full pass.
- Full pass at defaults: exactly 959 writes, last wraddr 958, done at T+1921.
